adder_rs: RTL and testbench

ADDER_RS -- requirements
Module: adder_rs

---
 rtl/adder_rs.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_adder_rs.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_rs.sv
// adder_rs: three-entry reservation station in front of the adder unit.
// Takes up to two dispatches per cycle, snoops the common data bus for
// outstanding operands, and issues at most one ready operation per cycle
// to the adder, lowest entry index first.

module adder_rs (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Adderin,
   input  logic        Adderin2,
   input  logic [15:0] Instr1,
   input  logic [15:0] Instr2,
   input  logic [15:0] Vj1,
   input  logic [2:0]  Qj1,
   input  logic [15:0] Vk1,
   input  logic [2:0]  Qk1,
   input  logic [15:0] Vj2,
   input  logic [2:0]  Qj2,
   input  logic [15:0] Vk2,
   input  logic [2:0]  Qk2,
   input  logic        CDBValid,
   input  logic [2:0]  CDBTag,
   input  logic [15:0] CDBData,
   input  logic        AdderReady,
   output logic        Accept1,
   output logic        Accept2,
   output logic [2:0]  Tag1,
   output logic [2:0]  Tag2,
   output logic        Issue,
   output logic [15:0] IssueInstr,
   output logic [15:0] IssueA,
   output logic [15:0] IssueB,
   output logic [2:0]  IssueTag
);

   localparam int unsigned NUM_ENTRIES = 3;

   // ------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------

   // Only ADD.D, SUB.D and BNE.D are handled by this station.
   function automatic logic f_opcode_ok(input logic [3:0] opcode);
      logic ok;
      case (opcode)
         4'b0000, 4'b0001, 4'b0010: ok = 1'b1;
         default:                   ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Index of the lowest set bit. Callers qualify the result with |vec,
   // so the all-zero case may return any index.
   function automatic logic [1:0] f_lowest(input logic [2:0] vec);
      logic [1:0] idx;
      if (vec[0]) begin
         idx = 2'd0;
      end else if (vec[1]) begin
         idx = 2'd1;
      end else begin
         idx = 2'd2;
      end
      return idx;
   endfunction

   // True when a pending producer tag is being broadcast on the CDB.
   function automatic logic f_cdb_hit(input logic [2:0] q,
                                      input logic       cdb_valid,
                                      input logic [2:0] cdb_tag);
      return cdb_valid && (q != 3'd0) && (q == cdb_tag);
   endfunction

   // ------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------
   logic [2:0]  r_busy;
   logic [15:0] r_instr [NUM_ENTRIES];
   logic [15:0] r_vj    [NUM_ENTRIES];
   logic [2:0]  r_qj    [NUM_ENTRIES];
   logic [15:0] r_vk    [NUM_ENTRIES];
   logic [2:0]  r_qk    [NUM_ENTRIES];

   logic        r_issue;
   logic [15:0] r_issue_instr;
   logic [15:0] r_issue_a;
   logic [15:0] r_issue_b;
   logic [2:0]  r_issue_tag;

   // ------------------------------------------------------------------
   // Combinational decisions
   // ------------------------------------------------------------------
   logic [2:0]  w_free;
   logic [2:0]  w_free_after1;
   logic [1:0]  w_idx1;
   logic [1:0]  w_idx2;
   logic        w_ok1;
   logic        w_ok2;
   logic [2:0]  w_slot1;
   logic [2:0]  w_slot2;

   logic [2:0]  w_ready;
   logic        w_do_issue;
   logic [1:0]  w_issue_idx;
   logic [2:0]  w_issue_sel;
   logic [15:0] w_sel_instr;
   logic [15:0] w_sel_a;
   logic [15:0] w_sel_b;

   logic [15:0] w_vj1_in;
   logic [2:0]  w_qj1_in;
   logic [15:0] w_vk1_in;
   logic [2:0]  w_qk1_in;
   logic [15:0] w_vj2_in;
   logic [2:0]  w_qj2_in;
   logic [15:0] w_vk2_in;
   logic [2:0]  w_qk2_in;

   // Slot allocation from pre-edge busy bits: dispatch 1 gets the lowest
   // free entry, dispatch 2 the lowest of whatever dispatch 1 left.
   always_comb begin
      w_free = ~r_busy;
      w_idx1 = f_lowest(w_free);
      w_ok1  = ~Reset & Adderin & f_opcode_ok(Instr1[3:0]) & (|w_free);
      if (w_ok1) begin
         w_slot1 = 3'b001 << w_idx1;
      end else begin
         w_slot1 = 3'b000;
      end
      w_free_after1 = w_free & ~w_slot1;
      w_idx2 = f_lowest(w_free_after1);
      w_ok2  = ~Reset & Adderin2 & f_opcode_ok(Instr2[3:0]) & (|w_free_after1);
      if (w_ok2) begin
         w_slot2 = 3'b001 << w_idx2;
      end else begin
         w_slot2 = 3'b000;
      end
   end

   // Handshake back to the dispatcher: accept flags and assigned tags.
   always_comb begin
      Accept1 = w_ok1;
      Accept2 = w_ok2;
      if (w_ok1) begin
         Tag1 = {1'b0, w_idx1} + 3'd1;
      end else begin
         Tag1 = 3'd0;
      end
      if (w_ok2) begin
         Tag2 = {1'b0, w_idx2} + 3'd1;
      end else begin
         Tag2 = 3'd0;
      end
   end

   // Readiness uses pre-edge operands only, so a value grabbed from the
   // CDB this cycle makes its entry issuable one edge later.
   always_comb begin
      w_ready = 3'b000;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         w_ready[i] = r_busy[i] && (r_qj[i] == 3'd0) && (r_qk[i] == 3'd0);
      end
      w_do_issue  = AdderReady & (|w_ready);
      w_issue_idx = f_lowest(w_ready);
      if (w_do_issue) begin
         w_issue_sel = 3'b001 << w_issue_idx;
      end else begin
         w_issue_sel = 3'b000;
      end
   end

   // Payload of the entry selected for issue.
   always_comb begin
      case (w_issue_idx)
         2'd0: begin
            w_sel_instr = r_instr[0];
            w_sel_a     = r_vj[0];
            w_sel_b     = r_vk[0];
         end
         2'd1: begin
            w_sel_instr = r_instr[1];
            w_sel_a     = r_vj[1];
            w_sel_b     = r_vk[1];
         end
         2'd2: begin
            w_sel_instr = r_instr[2];
            w_sel_a     = r_vj[2];
            w_sel_b     = r_vk[2];
         end
         default: begin
            w_sel_instr = r_instr[0];
            w_sel_a     = r_vj[0];
            w_sel_b     = r_vk[0];
         end
      endcase
   end

   // Dispatch bypass: an operand whose producer is broadcasting right now
   // is stored as already valid.
   always_comb begin
      if (f_cdb_hit(Qj1, CDBValid, CDBTag)) begin
         w_vj1_in = CDBData;
         w_qj1_in = 3'd0;
      end else begin
         w_vj1_in = Vj1;
         w_qj1_in = Qj1;
      end
      if (f_cdb_hit(Qk1, CDBValid, CDBTag)) begin
         w_vk1_in = CDBData;
         w_qk1_in = 3'd0;
      end else begin
         w_vk1_in = Vk1;
         w_qk1_in = Qk1;
      end
      if (f_cdb_hit(Qj2, CDBValid, CDBTag)) begin
         w_vj2_in = CDBData;
         w_qj2_in = 3'd0;
      end else begin
         w_vj2_in = Vj2;
         w_qj2_in = Qj2;
      end
      if (f_cdb_hit(Qk2, CDBValid, CDBTag)) begin
         w_vk2_in = CDBData;
         w_qk2_in = 3'd0;
      end else begin
         w_vk2_in = Vk2;
         w_qk2_in = Qk2;
      end
   end

   // ------------------------------------------------------------------
   // Sequential state
   // ------------------------------------------------------------------

   // Busy bits: issue frees an entry, dispatch claims free ones; the two
   // never touch the same entry because allocation sees pre-edge state.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_busy <= 3'b000;
      end else begin
         r_busy <= (r_busy & ~w_issue_sel) | w_slot1 | w_slot2;
      end
   end

   // Entry payload: load on dispatch, otherwise snoop the CDB while busy.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            r_instr[i] <= 16'h0000;
            r_vj[i]    <= 16'h0000;
            r_qj[i]    <= 3'd0;
            r_vk[i]    <= 16'h0000;
            r_qk[i]    <= 3'd0;
         end
      end else begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (w_slot1[i]) begin
               r_instr[i] <= Instr1;
               r_vj[i]    <= w_vj1_in;
               r_qj[i]    <= w_qj1_in;
               r_vk[i]    <= w_vk1_in;
               r_qk[i]    <= w_qk1_in;
            end else if (w_slot2[i]) begin
               r_instr[i] <= Instr2;
               r_vj[i]    <= w_vj2_in;
               r_qj[i]    <= w_qj2_in;
               r_vk[i]    <= w_vk2_in;
               r_qk[i]    <= w_qk2_in;
            end else if (r_busy[i]) begin
               if (f_cdb_hit(r_qj[i], CDBValid, CDBTag)) begin
                  r_vj[i] <= CDBData;
                  r_qj[i] <= 3'd0;
               end
               if (f_cdb_hit(r_qk[i], CDBValid, CDBTag)) begin
                  r_vk[i] <= CDBData;
                  r_qk[i] <= 3'd0;
               end
            end
         end
      end
   end

   // Issue port: one-cycle pulse; operand/tag fields hold between issues.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_issue       <= 1'b0;
         r_issue_instr <= 16'h0000;
         r_issue_a     <= 16'h0000;
         r_issue_b     <= 16'h0000;
         r_issue_tag   <= 3'd0;
      end else if (w_do_issue) begin
         r_issue       <= 1'b1;
         r_issue_instr <= w_sel_instr;
         r_issue_a     <= w_sel_a;
         r_issue_b     <= w_sel_b;
         r_issue_tag   <= {1'b0, w_issue_idx} + 3'd1;
      end else begin
         r_issue       <= 1'b0;
      end
   end

   assign Issue      = r_issue;
   assign IssueInstr = r_issue_instr;
   assign IssueA     = r_issue_a;
   assign IssueB     = r_issue_b;
   assign IssueTag   = r_issue_tag;

endmodule

// File: tb/tb_adder_rs.sv
// tb_adder_rs: directed scenarios plus randomized traffic for adder_rs,
// compared against a behavioural model of the reservation station.

module tb_adder_rs;

   logic        Clock;
   logic        Reset;
   logic        Adderin, Adderin2;
   logic [15:0] Instr1, Instr2;
   logic [15:0] Vj1, Vk1, Vj2, Vk2;
   logic [2:0]  Qj1, Qk1, Qj2, Qk2;
   logic        CDBValid;
   logic [2:0]  CDBTag;
   logic [15:0] CDBData;
   logic        AdderReady;
   logic        Accept1, Accept2;
   logic [2:0]  Tag1, Tag2;
   logic        Issue;
   logic [15:0] IssueInstr, IssueA, IssueB;
   logic [2:0]  IssueTag;

   adder_rs dut (
      .Clock(Clock), .Reset(Reset), .Adderin(Adderin), .Adderin2(Adderin2),
      .Instr1(Instr1), .Instr2(Instr2),
      .Vj1(Vj1), .Qj1(Qj1), .Vk1(Vk1), .Qk1(Qk1),
      .Vj2(Vj2), .Qj2(Qj2), .Vk2(Vk2), .Qk2(Qk2),
      .CDBValid(CDBValid), .CDBTag(CDBTag), .CDBData(CDBData),
      .AdderReady(AdderReady),
      .Accept1(Accept1), .Accept2(Accept2), .Tag1(Tag1), .Tag2(Tag2),
      .Issue(Issue), .IssueInstr(IssueInstr), .IssueA(IssueA),
      .IssueB(IssueB), .IssueTag(IssueTag)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   bit          m_busy  [3];
   logic [15:0] m_instr [3];
   logic [15:0] m_vj    [3];
   logic [15:0] m_vk    [3];
   logic [2:0]  m_qj    [3];
   logic [2:0]  m_qk    [3];
   bit          m_issue;
   logic [15:0] m_iinstr, m_ia, m_ib;
   int          m_itag;
   bit          e_acc1, e_acc2;
   int          e_tag1, e_tag2;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit op_ok(input logic [15:0] ins);
      return ins[3:0] <= 4'd2;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_busy[i] = 0;
         m_qj[i] = 3'd0;
         m_qk[i] = 3'd0;
      end
      m_issue = 0; m_iinstr = 16'h0; m_ia = 16'h0; m_ib = 16'h0; m_itag = 0;
   endtask

   // Expected dispatch handshake: free entries handed out in ascending order.
   task automatic model_comb();
      int q[$];
      for (int i = 0; i < 3; i++) if (!m_busy[i]) q.push_back(i);
      e_acc1 = 0; e_tag1 = 0; e_acc2 = 0; e_tag2 = 0;
      if (!Reset && Adderin && op_ok(Instr1) && q.size() > 0) begin
         e_acc1 = 1; e_tag1 = q.pop_front() + 1;
      end
      if (!Reset && Adderin2 && op_ok(Instr2) && q.size() > 0) begin
         e_acc2 = 1; e_tag2 = q.pop_front() + 1;
      end
   endtask

   task automatic model_put(input int idx, input logic [15:0] ins,
                            input logic [15:0] vj, input logic [2:0] qj,
                            input logic [15:0] vk, input logic [2:0] qk);
      m_busy[idx] = 1; m_instr[idx] = ins;
      if (CDBValid && qj != 0 && qj == CDBTag) begin m_vj[idx] = CDBData; m_qj[idx] = 0; end
      else begin m_vj[idx] = vj; m_qj[idx] = qj; end
      if (CDBValid && qk != 0 && qk == CDBTag) begin m_vk[idx] = CDBData; m_qk[idx] = 0; end
      else begin m_vk[idx] = vk; m_qk[idx] = qk; end
   endtask

   // What one clock edge does to the station.
   task automatic model_edge();
      int sel = -1;
      if (Reset) begin
         model_reset();
         return;
      end
      if (AdderReady)
         for (int i = 0; i < 3; i++)
            if (sel < 0 && m_busy[i] && m_qj[i] == 0 && m_qk[i] == 0) sel = i;
      if (sel >= 0) begin
         m_issue = 1; m_iinstr = m_instr[sel]; m_ia = m_vj[sel]; m_ib = m_vk[sel];
         m_itag = sel + 1; m_busy[sel] = 0;
      end else begin
         m_issue = 0;
      end
      for (int i = 0; i < 3; i++) begin
         if (m_busy[i] && CDBValid && m_qj[i] != 0 && m_qj[i] == CDBTag) begin
            m_vj[i] = CDBData; m_qj[i] = 0;
         end
         if (m_busy[i] && CDBValid && m_qk[i] != 0 && m_qk[i] == CDBTag) begin
            m_vk[i] = CDBData; m_qk[i] = 0;
         end
      end
      if (e_acc1) model_put(e_tag1 - 1, Instr1, Vj1, Qj1, Vk1, Qk1);
      if (e_acc2) model_put(e_tag2 - 1, Instr2, Vj2, Qj2, Vk2, Qk2);
   endtask

   // Called just after a falling edge with inputs already driven.
   task automatic settle_check();
      #1;
      model_comb();
      check_val("accept1", Accept1, e_acc1);
      check_val("accept2", Accept2, e_acc2);
      check_val("tag1", Tag1, e_tag1);
      check_val("tag2", Tag2, e_tag2);
   endtask

   task automatic edge_check();
      @(posedge Clock);
      model_edge();
      #1;
      check_val("issue", Issue, m_issue);
      check_val("issue_instr", IssueInstr, m_iinstr);
      check_val("issue_a", IssueA, m_ia);
      check_val("issue_b", IssueB, m_ib);
      check_val("issue_tag", IssueTag, m_itag);
      @(negedge Clock);
   endtask

   task automatic step();
      settle_check();
      edge_check();
   endtask

   task automatic idle();
      Adderin = 0; Adderin2 = 0; Instr1 = 16'h0; Instr2 = 16'h0;
      Vj1 = 16'h0; Vk1 = 16'h0; Vj2 = 16'h0; Vk2 = 16'h0;
      Qj1 = 3'd0; Qk1 = 3'd0; Qj2 = 3'd0; Qk2 = 3'd0;
      CDBValid = 0; CDBTag = 3'd0; CDBData = 16'h0; AdderReady = 0;
   endtask

   function automatic logic [2:0] rnd_q();
      if ($urandom_range(0, 1) == 0) return 3'd0;
      return 3'($urandom_range(1, 7));
   endfunction

   initial begin
      Reset = 1'b1;
      idle();
      model_reset();
      @(negedge Clock);
      Adderin = 1;
      step();
      check_val("rst_accept1", Accept1, 0);
      check_val("rst_issue", Issue, 0);
      Reset = 1'b0;
      idle();
      step();

      // Two dispatches into an empty station, then two issues in order.
      Adderin = 1; Adderin2 = 1; Instr1 = 16'h0021; Instr2 = 16'h0001;
      Vj1 = 16'h1111; Vk1 = 16'h2222; Vj2 = 16'h3333; Vk2 = 16'h4444; AdderReady = 1;
      settle_check();
      check_val("dual_tag1", Tag1, 1);
      check_val("dual_tag2", Tag2, 2);
      edge_check();
      check_val("dual_no_issue", Issue, 0);
      idle(); AdderReady = 1;
      step();
      check_val("dual_iss1_tag", IssueTag, 1);
      check_val("dual_iss1_a", IssueA, 16'h1111);
      check_val("dual_iss1_b", IssueB, 16'h2222);
      check_val("dual_iss1_instr", IssueInstr, 16'h0021);
      step();
      check_val("dual_iss2_tag", IssueTag, 2);
      check_val("dual_iss2_a", IssueA, 16'h3333);
      check_val("dual_iss2_b", IssueB, 16'h4444);
      step();
      check_val("dual_drained", Issue, 0);

      // Full station, then a freed entry is reusable only on the next cycle.
      idle(); Adderin = 1; Adderin2 = 1; Instr1 = 16'h0001; Instr2 = 16'h0002;
      Vj1 = 16'h0A0A; Vk1 = 16'h0B0B; Vj2 = 16'h0C0C; Vk2 = 16'h0D0D;
      step();
      Adderin2 = 0; Instr1 = 16'h0000;
      step();
      AdderReady = 1;
      settle_check();
      check_val("full_accept1", Accept1, 0);
      edge_check();
      settle_check();
      check_val("freed_accept1", Accept1, 1);
      check_val("freed_tag1", Tag1, 1);
      edge_check();
      idle(); AdderReady = 1;
      repeat (4) step();

      // Unsupported opcode is refused and leaves nothing behind.
      idle(); Adderin = 1; Instr1 = 16'h0013; AdderReady = 1;
      settle_check();
      check_val("badop_accept1", Accept1, 0);
      check_val("badop_tag1", Tag1, 0);
      edge_check();
      idle(); AdderReady = 1;
      step();
      check_val("badop_no_issue", Issue, 0);

      // Waiting operand captured from the CDB, issued one edge later.
      idle(); Adderin = 1; Instr1 = 16'h0000; Qj1 = 3'd5; Vj1 = 16'hDEAD;
      Vk1 = 16'h0042; AdderReady = 1;
      step();
      idle(); AdderReady = 1; CDBValid = 1; CDBTag = 3'd5; CDBData = 16'h1234;
      step();
      check_val("cdb_not_yet", Issue, 0);
      idle(); AdderReady = 1;
      step();
      check_val("cdb_issue", Issue, 1);
      check_val("cdb_issue_a", IssueA, 16'h1234);
      check_val("cdb_issue_b", IssueB, 16'h0042);

      // Dispatch-time bypass of a broadcast operand.
      idle(); Adderin = 1; Instr1 = 16'h0001; Qk1 = 3'd6; Vk1 = 16'hBEEF;
      Vj1 = 16'h0007; CDBValid = 1; CDBTag = 3'd6; CDBData = 16'h00FF; AdderReady = 1;
      step();
      idle(); AdderReady = 1;
      step();
      check_val("bypass_issue", Issue, 1);
      check_val("bypass_issue_b", IssueB, 16'h00FF);
      check_val("bypass_issue_a", IssueA, 16'h0007);

      // Asynchronous reset between edges with two entries still busy.
      idle(); Adderin = 1; Adderin2 = 1; Instr1 = 16'h0001; Instr2 = 16'h0000;
      Vj1 = 16'h5555; Vk1 = 16'h6666;
      step();
      Adderin2 = 0;
      step();
      idle(); AdderReady = 1;
      step();
      check_val("pre_rst_issue", Issue, 1);
      #2;
      Reset = 1'b1; Adderin = 1; Instr1 = 16'h0000;
      #1;
      check_val("async_rst_issue", Issue, 0);
      check_val("async_rst_tag", IssueTag, 0);
      check_val("async_rst_a", IssueA, 0);
      check_val("async_rst_accept1", Accept1, 0);
      model_reset();
      @(posedge Clock);
      @(negedge Clock);
      Reset = 1'b0;
      idle(); AdderReady = 1;
      step();
      check_val("post_rst_idle1", Issue, 0);
      step();
      check_val("post_rst_idle2", Issue, 0);

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         Reset      = ($urandom_range(0, 199) == 0);
         Adderin    = $urandom_range(0, 1);
         Adderin2   = $urandom_range(0, 1);
         Instr1     = {12'($urandom), 4'($urandom_range(0, 4))};
         Instr2     = {12'($urandom), 4'($urandom_range(0, 4))};
         Vj1 = 16'($urandom); Vk1 = 16'($urandom);
         Vj2 = 16'($urandom); Vk2 = 16'($urandom);
         Qj1 = rnd_q(); Qk1 = rnd_q(); Qj2 = rnd_q(); Qk2 = rnd_q();
         CDBValid   = $urandom_range(0, 1);
         CDBTag     = 3'($urandom_range(1, 7));
         CDBData    = 16'($urandom);
         AdderReady = ($urandom_range(0, 9) < 7);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
